// File: rtl/tech_sff_pipe_pkg.sv
// Shared constants for the tech_sff register-chain cells: clock-edge selector codes
// and the clog2 helper that sizes the occupancy counter.
package tech_sff_pipe_pkg;

    localparam int TECH_SFF_EDGE_POS = 0;
    localparam int TECH_SFF_EDGE_NEG = 1;

    // Ceiling log2, with a minimum of 1 so a 1-deep pipe still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/tech_sff_stage.sv
// One WIDTH-bit pipeline register plus its valid bit, on the clock edge chosen by CLK_NEG,
// with an asynchronous active-low reset that loads RESET_VAL and clears the valid bit.
module tech_sff_stage
    import tech_sff_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CLK_NEG   = TECH_SFF_EDGE_NEG,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_ld,
    input  logic [WIDTH-1:0] data_in,
    input  logic             vld_ld,
    input  logic             vld_in,
    input  logic             vld_clr,
    output logic [WIDTH-1:0] data,
    output logic             vld
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d,  vld_q;

    // NOTE: every variable gets its hold value first, so no path through the block can infer a latch.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (data_ld) data_d = data_in;
        if (vld_clr)     vld_d = 1'b0;
        else if (vld_ld) vld_d = vld_in;
    end

    generate
        if (CLK_NEG == TECH_SFF_EDGE_NEG) begin : g_neg
            // NOTE: sequential state uses <= so every stage samples its neighbour's pre-edge value.
            always_ff @(negedge clk or negedge rst) begin
                if (!rst) begin
                    data_q <= RESET_VAL;
                    vld_q  <= 1'b0;
                end else begin
                    data_q <= data_d;
                    vld_q  <= vld_d;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_q <= RESET_VAL;
                    vld_q  <= 1'b0;
                end else begin
                    data_q <= data_d;
                    vld_q  <= vld_d;
                end
            end
        end
    endgenerate

    assign data = data_q;
    assign vld  = vld_q;

endmodule

// File: rtl/tech_sff_pipe.sv
// WIDTH x DEPTH preset/clear register chain with valid tracking and occupancy count.
// Define SFF_PIPE_SCAN_EN to add a serial scan chain through all data bits.
module tech_sff_pipe
    import tech_sff_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter int               CLK_NEG   = TECH_SFF_EDGE_NEG,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          in_vld,
    input  logic [WIDTH-1:0]              d,
    output logic [WIDTH-1:0]              q,
    output logic                          out_vld,
    output logic [clog2(DEPTH+1)-1:0]     occ
`ifdef SFF_PIPE_SCAN_EN
    ,
    input  logic                          scan_en,
    input  logic                          scan_in,
    output logic                          scan_out
`endif
);

    localparam int OCC_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;
    logic             scan_act;
    logic             scan_bit_in;
    logic             shift;
    logic [OCC_W-1:0] occ_d, occ_q;

`ifdef SFF_PIPE_SCAN_EN
    assign scan_act    = scan_en & ~flush;
    assign scan_bit_in = scan_in;
    assign scan_out    = stage_data[DEPTH-1][WIDTH-1];
`else
    assign scan_act    = 1'b0;
    assign scan_bit_in = 1'b0;
`endif

    assign shift = en & ~flush & ~scan_act;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic [WIDTH-1:0] prev_data;
            logic             prev_vld;
            logic             scan_prev;
            logic [WIDTH-1:0] scan_data;

            if (k == 0) begin : g_head
                assign prev_data = d;
                assign prev_vld  = in_vld;
                assign scan_prev = scan_bit_in;
            end else begin : g_body
                assign prev_data = stage_data[k-1];
                assign prev_vld  = stage_vld[k-1];
                assign scan_prev = stage_data[k-1][WIDTH-1];
            end

            // Scan enters at bit 0 and leaves at bit WIDTH-1 into the next stage.
            if (WIDTH == 1) begin : g_scan_w1
                assign scan_data = scan_prev;
            end else begin : g_scan_wn
                assign scan_data = {stage_data[k][WIDTH-2:0], scan_prev};
            end

            tech_sff_stage #(
                .WIDTH    (WIDTH),
                .CLK_NEG  (CLK_NEG),
                .RESET_VAL(RESET_VAL)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .data_ld(shift | scan_act),
                .data_in(scan_act ? scan_data : prev_data),
                .vld_ld (shift),
                .vld_in (prev_vld),
                .vld_clr(flush),
                .data   (stage_data[k]),
                .vld    (stage_vld[k])
            );
        end
    endgenerate

    // Modular add/subtract stays exact because the true result is always within 0..DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (flush)      occ_d = '0;
        else if (shift) occ_d = occ_q + OCC_W'(in_vld) - OCC_W'(stage_vld[DEPTH-1]);
    end

    generate
        if (CLK_NEG == TECH_SFF_EDGE_NEG) begin : g_occ_neg
            // NOTE: the counter must be reset along with the stages, or occ would disagree with the valids.
            always_ff @(negedge clk or negedge rst) begin
                if (!rst) occ_q <= '0;
                else      occ_q <= occ_d;
            end
        end else begin : g_occ_pos
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) occ_q <= '0;
                else      occ_q <= occ_d;
            end
        end
    endgenerate

    assign q       = stage_data[DEPTH-1];
    assign out_vld = stage_vld[DEPTH-1];
    assign occ     = occ_q;

endmodule
